// File: rtl/mc_datapath.sv
// Single-bus CPU datapath: register file plus special registers, a single-cycle ALU,
// and an iterative signed multiply/divide unit that writes the 2*WIDTH Z register.
module mc_datapath #(
  parameter int WIDTH   = 32,
  parameter int NREGS   = 16,
  parameter int CONST_W = 19,
  parameter int R0_ZERO = 1
) (
  input  logic              clk,
  input  logic              clr,
  input  logic [NREGS-1:0]  reg_in,
  input  logic              hi_in,
  input  logic              lo_in,
  input  logic              y_in,
  input  logic              pc_in,
  input  logic              ir_in,
  input  logic              mar_in,
  input  logic              outport_in,
  input  logic              inport_in,
  input  logic              z_in,
  input  logic              mdr_in,
  input  logic              md_read,
  input  logic              pc_inc,
  input  logic [4:0]        bus_sel,
  input  logic [3:0]        alu_op,
  input  logic              alu_start,
  input  logic [WIDTH-1:0]  mem_data_in,
  input  logic [WIDTH-1:0]  in_port_data,
  output logic [WIDTH-1:0]  bus_out,
  output logic              busy,
  output logic              done,
  output logic              div_zero,
  output logic [WIDTH-1:0]  hi_out,
  output logic [WIDTH-1:0]  lo_out,
  output logic [WIDTH-1:0]  pc_out,
  output logic [WIDTH-1:0]  mar_out,
  output logic [WIDTH-1:0]  out_port
);

  localparam int SW = $clog2(WIDTH);

  typedef enum logic {MD_IDLE, MD_RUN} mdStateT;

  logic [WIDTH-1:0]   regs [NREGS];
  logic [WIDTH-1:0]   hi, lo, y, pc, mdr, mar, inport, outport;
  logic [CONST_W-1:0] irConst;
  logic [2*WIDTH-1:0] z;
  logic [WIDTH-1:0]   cConst, aluResult;
  logic [2*WIDTH-1:0] rorWide, rolWide;
  logic [SW-1:0]      shamt;

  mdStateT            mdState, mdNext;
  logic [WIDTH:0]     mdAcc, mdM, stepAcc, addSub, shR, trial;
  logic [WIDTH-1:0]   mdQ, stepQ, mdDividend, quo, rem;
  logic               mdQm1, stepQm1, mdIsDiv, mdNegQ, mdNegR, mdBZero;
  logic [SW-1:0]      mdCount;
  logic [2*WIDTH-1:0] mdResult;
  logic               startOk, mdLast, isMulDiv;
  logic [WIDTH-1:0]   absA, absB;

  assign cConst   = {{(WIDTH-CONST_W){irConst[CONST_W-1]}}, irConst};
  assign isMulDiv = (alu_op == 4'd9) || (alu_op == 4'd10);
  assign startOk  = alu_start && !busy && isMulDiv;
  assign mdLast   = busy && (mdCount == SW'(WIDTH-1));
  assign shamt    = bus_out[SW-1:0];
  assign absA     = y[WIDTH-1] ? -y : y;
  assign absB     = bus_out[WIDTH-1] ? -bus_out : bus_out;

  // Bus source mux; R0 reads as zero when R0_ZERO is set, unmapped codes read zero
  always_comb begin
    bus_out = '0;
    for (int i = 0; i < NREGS; i++)
      if (bus_sel == 5'(i) && (R0_ZERO == 0 || i != 0)) bus_out = regs[i];
    case (bus_sel)
      5'd16:   bus_out = hi;
      5'd17:   bus_out = lo;
      5'd18:   bus_out = z[2*WIDTH-1:WIDTH];
      5'd19:   bus_out = z[WIDTH-1:0];
      5'd20:   bus_out = pc;
      5'd21:   bus_out = mdr;
      5'd22:   bus_out = inport;
      5'd23:   bus_out = cConst;
      default: ;
    endcase
  end

  // Single-cycle ALU; rotates use a doubled word so the wrapped bits fall into place
  always_comb begin
    aluResult = '0;
    rorWide   = {y, y} >> shamt;
    rolWide   = {y, y} << shamt;
    case (alu_op)
      4'd0:    aluResult = y + bus_out;
      4'd1:    aluResult = y - bus_out;
      4'd2:    aluResult = y & bus_out;
      4'd3:    aluResult = y | bus_out;
      4'd4:    aluResult = y >> shamt;
      4'd5:    aluResult = $signed(y) >>> shamt;
      4'd6:    aluResult = y << shamt;
      4'd7:    aluResult = rorWide[WIDTH-1:0];
      4'd8:    aluResult = rolWide[2*WIDTH-1:WIDTH];
      4'd11:   aluResult = -bus_out;
      4'd12:   aluResult = ~bus_out;
      default: aluResult = '0;
    endcase
  end

  // One Booth or restoring-division step; the final step's outcome goes straight into Z
  always_comb begin
    addSub  = mdAcc;
    shR     = {mdAcc[WIDTH-1:0], mdQ[WIDTH-1]};
    trial   = shR - mdM;
    stepAcc = mdAcc;
    stepQ   = mdQ;
    stepQm1 = 1'b0;
    quo     = '0;
    rem     = '0;
    if (!mdIsDiv) begin
      case ({mdQ[0], mdQm1})
        2'b01:   addSub = mdAcc + mdM;
        2'b10:   addSub = mdAcc - mdM;
        default: addSub = mdAcc;
      endcase
      stepAcc  = {addSub[WIDTH], addSub[WIDTH:1]};
      stepQ    = {addSub[0], mdQ[WIDTH-1:1]};
      stepQm1  = mdQ[0];
      mdResult = {stepAcc[WIDTH-1:0], stepQ};
    end else begin
      if (!trial[WIDTH]) begin
        stepAcc = trial;
        stepQ   = {mdQ[WIDTH-2:0], 1'b1};
      end else begin
        stepAcc = shR;
        stepQ   = {mdQ[WIDTH-2:0], 1'b0};
      end
      quo = mdNegQ ? -stepQ : stepQ;
      rem = mdNegR ? -stepAcc[WIDTH-1:0] : stepAcc[WIDTH-1:0];
      mdResult = mdBZero ? {mdDividend, {WIDTH{1'b1}}} : {rem, quo};
    end
  end

  always_ff @(posedge clk or posedge clr) begin
    if (clr) mdState <= MD_IDLE;
    else     mdState <= mdNext;
  end

  always_comb begin
    mdNext = mdState;
    case (mdState)
      MD_IDLE: if (startOk) mdNext = MD_RUN;
      MD_RUN:  if (mdLast)  mdNext = MD_IDLE;
      default: mdNext = MD_IDLE;
    endcase
  end

  always_comb begin
    busy = (mdState == MD_RUN);
  end

  // Multiply/divide operand capture and iteration
  always_ff @(posedge clk or posedge clr) begin
    if (clr) begin
      mdAcc <= '0; mdM <= '0; mdQ <= '0; mdQm1 <= 1'b0; mdIsDiv <= 1'b0;
      mdNegQ <= 1'b0; mdNegR <= 1'b0; mdBZero <= 1'b0; mdDividend <= '0;
      mdCount <= '0; done <= 1'b0; div_zero <= 1'b0;
    end else begin
      done <= mdLast;
      if (startOk) begin
        mdAcc      <= '0;
        mdQm1      <= 1'b0;
        mdCount    <= '0;
        mdIsDiv    <= (alu_op == 4'd10);
        mdNegQ     <= y[WIDTH-1] ^ bus_out[WIDTH-1];
        mdNegR     <= y[WIDTH-1];
        mdBZero    <= (bus_out == '0);
        mdDividend <= y;
        div_zero   <= 1'b0;
        mdQ        <= (alu_op == 4'd10) ? absA : bus_out;
        mdM        <= (alu_op == 4'd10) ? {1'b0, absB} : {y[WIDTH-1], y};
      end else if (busy) begin
        mdAcc   <= stepAcc;
        mdQ     <= stepQ;
        mdQm1   <= stepQm1;
        mdCount <= mdCount + SW'(1);
        if (mdLast) div_zero <= mdIsDiv && mdBZero;
      end
    end
  end

  // Architectural registers; Z belongs to the multi-cycle unit while it is busy
  always_ff @(posedge clk or posedge clr) begin
    if (clr) begin
      for (int i = 0; i < NREGS; i++) regs[i] <= '0;
      hi <= '0; lo <= '0; y <= '0; pc <= '0; mdr <= '0; mar <= '0;
      inport <= '0; outport <= '0; irConst <= '0; z <= '0;
    end else begin
      for (int i = 0; i < NREGS; i++)
        if (reg_in[i]) regs[i] <= bus_out;
      if (hi_in)      hi      <= bus_out;
      if (lo_in)      lo      <= bus_out;
      if (y_in)       y       <= bus_out;
      if (mar_in)     mar     <= bus_out;
      if (outport_in) outport <= bus_out;
      if (ir_in)      irConst <= bus_out[CONST_W-1:0];
      if (inport_in)  inport  <= in_port_data;
      if (mdr_in)     mdr     <= md_read ? mem_data_in : bus_out;
      if (pc_in)       pc <= bus_out;
      else if (pc_inc) pc <= pc + WIDTH'(1);
      if (mdLast) z <= mdResult;
      else if (z_in && !busy && !isMulDiv) z <= {{WIDTH{1'b0}}, aluResult};
    end
  end

  assign hi_out   = hi;
  assign lo_out   = lo;
  assign pc_out   = pc;
  assign mar_out  = mar;
  assign out_port = outport;

endmodule

// File: tb/tb_mc_datapath.sv
// Bench for mc_datapath: register transfers, a table of single-cycle ALU vectors,
// and a scoreboard of multiply/divide results checked when done pulses.
module tb_mc_datapath;

  localparam int WIDTH = 32;
  localparam int NREGS = 16;

  logic             clk, clr;
  logic [NREGS-1:0] reg_in;
  logic             hi_in, lo_in, y_in, pc_in, ir_in, mar_in, outport_in, inport_in;
  logic             z_in, mdr_in, md_read, pc_inc, alu_start;
  logic [4:0]       bus_sel;
  logic [3:0]       alu_op;
  logic [WIDTH-1:0] mem_data_in, in_port_data;
  logic [WIDTH-1:0] bus_out, hi_out, lo_out, pc_out, mar_out, out_port;
  logic             busy, done, div_zero;

  mc_datapath #(.WIDTH(WIDTH), .NREGS(NREGS), .CONST_W(19), .R0_ZERO(1)) dut (
    .clk(clk), .clr(clr), .reg_in(reg_in),
    .hi_in(hi_in), .lo_in(lo_in), .y_in(y_in), .pc_in(pc_in), .ir_in(ir_in),
    .mar_in(mar_in), .outport_in(outport_in), .inport_in(inport_in),
    .z_in(z_in), .mdr_in(mdr_in), .md_read(md_read), .pc_inc(pc_inc),
    .bus_sel(bus_sel), .alu_op(alu_op), .alu_start(alu_start),
    .mem_data_in(mem_data_in), .in_port_data(in_port_data),
    .bus_out(bus_out), .busy(busy), .done(done), .div_zero(div_zero),
    .hi_out(hi_out), .lo_out(lo_out), .pc_out(pc_out), .mar_out(mar_out),
    .out_port(out_port)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct { logic [31:0] zhi; logic [31:0] zlo; logic dz; } expT;
  typedef struct { string name; logic [3:0] op; logic [31:0] a; logic [31:0] b; logic [31:0] expLo; } aluVecT;

  expT    sbQ[$];
  aluVecT aluVecs[14];
  int     assertCount = 0;
  int     failCount   = 0;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic checkOutput(input string name, input logic [63:0] actual, input logic [63:0] expected);
    assertCount++;
    if (actual !== expected) begin
      failCount++;
      $display("[TB] FAIL %s: got %h, expected %h", name, actual, expected);
    end
  endtask

  task automatic clearStrobes();
    reg_in = '0; hi_in = 0; lo_in = 0; y_in = 0; pc_in = 0; ir_in = 0; mar_in = 0;
    outport_in = 0; inport_in = 0; z_in = 0; mdr_in = 0; md_read = 0; pc_inc = 0;
    alu_start = 0; alu_op = '0; bus_sel = '0;
  endtask

  task automatic loadMdr(input logic [31:0] v);
    mem_data_in = v; md_read = 1; mdr_in = 1;
    tick();
    mdr_in = 0; md_read = 0;
  endtask

  task automatic loadY(input logic [31:0] v);
    loadMdr(v);
    bus_sel = 5'd21; y_in = 1;
    tick();
    y_in = 0;
  endtask

  task automatic readBus(input logic [4:0] sel, output logic [31:0] v);
    bus_sel = sel;
    #1;
    v = bus_out;
  endtask

  // Pops the oldest expected Z/div_zero and compares against what the DUT holds now
  task automatic sbCheck(input string name);
    expT e;
    logic [31:0] hiV, loV;
    checkOutput({name, "_sbAvail"}, 64'(sbQ.size() > 0), 64'd1);
    if (sbQ.size() > 0) begin
      e = sbQ.pop_front();
      readBus(5'd18, hiV);
      readBus(5'd19, loV);
      checkOutput({name, "_zhi"}, 64'(hiV), 64'(e.zhi));
      checkOutput({name, "_zlo"}, 64'(loV), 64'(e.zlo));
      checkOutput({name, "_divZero"}, 64'(div_zero), 64'(e.dz));
    end
    bus_sel = 5'd21;
  endtask

  task automatic applyStimulus(input aluVecT v);
    loadY(v.a);
    loadMdr(v.b);
    bus_sel = 5'd21; alu_op = v.op; z_in = 1;
    sbQ.push_back('{32'd0, v.expLo, 1'b0});
    tick();
    z_in = 0; alu_op = '0;
    sbCheck(v.name);
  endtask

  task automatic startOp(input string name, input logic [3:0] op, input logic [31:0] a, input logic [31:0] b,
                         input logic [31:0] eHi, input logic [31:0] eLo, input logic eDz);
    loadY(a);
    loadMdr(b);
    bus_sel = 5'd21; alu_op = op; alu_start = 1;
    sbQ.push_back('{eHi, eLo, eDz});
    tick();
    alu_start = 0; alu_op = '0;
    checkOutput({name, "_busyRise"}, 64'(busy), 64'd1);
    checkOutput({name, "_divZeroCleared"}, 64'(div_zero), 64'd0);
  endtask

  // Counts edges until done; optionally pokes the DUT with ignored requests mid-operation
  task automatic waitDone(input string name, input int inject);
    int cycles = 0;
    while (!done && cycles < 100) begin
      if (inject != 0) begin
        if (cycles == 4) begin alu_start = 1; alu_op = 4'd10; end
        if (cycles == 5) begin alu_start = 0; alu_op = 4'd0; z_in = 1; end
        if (cycles == 6) begin z_in = 0; bus_sel = 5'd21; y_in = 1; end
        if (cycles == 7) begin y_in = 0; bus_sel = 5'd0; end
      end
      tick();
      cycles++;
      if (cycles == 16) checkOutput({name, "_busyMid"}, 64'(busy), 64'd1);
    end
    checkOutput({name, "_latency"}, 64'(cycles), 64'(WIDTH));
    checkOutput({name, "_busyFall"}, 64'(busy), 64'd0);
  endtask

  initial begin
    logic [31:0] v;
    int          sawDone;

    aluVecs[0]  = '{"aluAdd",    4'd0,  32'd5,          32'd7,          32'd12};
    aluVecs[1]  = '{"aluSub",    4'd1,  32'd3,          32'd5,          32'hFFFF_FFFE};
    aluVecs[2]  = '{"aluAnd",    4'd2,  32'hF0F0_F0F0,  32'hFF00_FF00,  32'hF000_F000};
    aluVecs[3]  = '{"aluOr",     4'd3,  32'h0F0F_0000,  32'h0000_00FF,  32'h0F0F_00FF};
    aluVecs[4]  = '{"aluShr",    4'd4,  32'h8000_0000,  32'd4,          32'h0800_0000};
    aluVecs[5]  = '{"aluShra",   4'd5,  32'h8000_0000,  32'd4,          32'hF800_0000};
    aluVecs[6]  = '{"aluShl",    4'd6,  32'h0000_0003,  32'd31,         32'h8000_0000};
    aluVecs[7]  = '{"aluRor",    4'd7,  32'h0000_0001,  32'd1,          32'h8000_0000};
    aluVecs[8]  = '{"aluRol",    4'd8,  32'h8000_0001,  32'd1,          32'h0000_0003};
    aluVecs[9]  = '{"aluNeg",    4'd11, 32'd0,          32'd5,          32'hFFFF_FFFB};
    aluVecs[10] = '{"aluNot",    4'd12, 32'd0,          32'h0000_FFFF,  32'hFFFF_0000};
    aluVecs[11] = '{"aluAddWrap",4'd0,  32'hFFFF_FFFF,  32'd1,          32'd0};
    aluVecs[12] = '{"aluShrMask",4'd4,  32'h8000_0000,  32'h0000_0021,  32'h4000_0000};
    aluVecs[13] = '{"aluUnused", 4'd13, 32'h0000_1234,  32'd1,          32'd0};

    clearStrobes();
    mem_data_in = '0; in_port_data = '0;

    // Reset held with strobes active
    clr = 1;
    reg_in = 16'($urandom); hi_in = 1; lo_in = 1; y_in = 1; pc_in = 1; ir_in = 1; mar_in = 1;
    outport_in = 1; inport_in = 1; z_in = 1; mdr_in = 1; md_read = 1; pc_inc = 1;
    alu_start = 1; alu_op = 4'd9; bus_sel = 5'($urandom_range(0, 31));
    mem_data_in = $urandom; in_port_data = $urandom;
    repeat (3) tick();
    checkOutput("rstBus", 64'(bus_out), 64'd0);
    checkOutput("rstBusy", 64'(busy), 64'd0);
    checkOutput("rstDone", 64'(done), 64'd0);
    checkOutput("rstDivZero", 64'(div_zero), 64'd0);
    checkOutput("rstHi", 64'(hi_out), 64'd0);
    checkOutput("rstLo", 64'(lo_out), 64'd0);
    checkOutput("rstPc", 64'(pc_out), 64'd0);
    checkOutput("rstMar", 64'(mar_out), 64'd0);
    checkOutput("rstOutPort", 64'(out_port), 64'd0);
    clearStrobes();
    clr = 0;
    pc_inc = 1;
    repeat (3) tick();
    pc_inc = 0;
    checkOutput("pcInc3", 64'(pc_out), 64'd3);
    readBus(5'd20, v); checkOutput("busPc", 64'(v), 64'd3);

    // Register transfers
    loadMdr(32'h12);
    bus_sel = 5'd21; reg_in = 16'h0004; tick(); reg_in = '0;
    readBus(5'd2, v); checkOutput("r2Load", 64'(v), 64'h12);
    loadMdr(32'h55);
    bus_sel = 5'd21; reg_in = 16'h0001; tick(); reg_in = '0;
    readBus(5'd0, v); checkOutput("r0ReadsZero", 64'(v), 64'd0);
    readBus(5'd2, v); checkOutput("r2Kept", 64'(v), 64'h12);
    bus_sel = 5'd2; hi_in = 1; lo_in = 1; mar_in = 1; outport_in = 1; tick();
    hi_in = 0; lo_in = 0; mar_in = 0; outport_in = 0;
    checkOutput("multiHi", 64'(hi_out), 64'h12);
    checkOutput("multiLo", 64'(lo_out), 64'h12);
    checkOutput("multiMar", 64'(mar_out), 64'h12);
    checkOutput("multiOut", 64'(out_port), 64'h12);
    readBus(5'd17, v); checkOutput("busLo", 64'(v), 64'h12);
    in_port_data = 32'hABCD; inport_in = 1; tick(); inport_in = 0;
    readBus(5'd22, v); checkOutput("inport", 64'(v), 64'hABCD);
    bus_sel = 5'd22; mem_data_in = 32'hDEAD; md_read = 0; mdr_in = 1; tick(); mdr_in = 0;
    readBus(5'd21, v); checkOutput("mdrFromBus", 64'(v), 64'hABCD);
    loadMdr(32'h0004_0001);
    bus_sel = 5'd21; ir_in = 1; tick(); ir_in = 0;
    readBus(5'd23, v); checkOutput("constSext", 64'(v), 64'hFFFC_0001);
    bus_sel = 5'd23; pc_in = 1; pc_inc = 1; tick(); pc_in = 0; pc_inc = 0;
    checkOutput("pcInPriority", 64'(pc_out), 64'hFFFC_0001);
    readBus(5'd24, v); checkOutput("busSel24", 64'(v), 64'd0);
    readBus(5'd31, v); checkOutput("busSel31", 64'(v), 64'd0);
    loadMdr(32'hFFFF_FFFF);
    bus_sel = 5'd21; pc_in = 1; tick(); pc_in = 0;
    pc_inc = 1; tick(); pc_inc = 0;
    checkOutput("pcWrap", 64'(pc_out), 64'd0);

    // Single-cycle ALU table
    for (int i = 0; i < 14; i++) applyStimulus(aluVecs[i]);

    // Multiply with ignored start, ignored z_in and operand changes during busy
    startOp("mulNeg", 4'd9, 32'hFFFF_FFFD, 32'd6, 32'hFFFF_FFFF, 32'hFFFF_FFEE, 1'b0);
    waitDone("mulNeg", 1);
    checkOutput("mulNeg_doneHigh", 64'(done), 64'd1);
    sbCheck("mulNeg");
    tick();
    checkOutput("donePulseOnce", 64'(done), 64'd0);

    startOp("mulMinSq", 4'd9, 32'h8000_0000, 32'h8000_0000, 32'h4000_0000, 32'd0, 1'b0);
    waitDone("mulMinSq", 0); sbCheck("mulMinSq");
    startOp("divNegPos", 4'd10, 32'hFFFF_FFF9, 32'd2, 32'hFFFF_FFFF, 32'hFFFF_FFFD, 1'b0);
    waitDone("divNegPos", 0); sbCheck("divNegPos");
    startOp("divNegNeg", 4'd10, 32'hFFFF_FFEC, 32'hFFFF_FFFA, 32'hFFFF_FFFE, 32'd3, 1'b0);
    waitDone("divNegNeg", 0); sbCheck("divNegNeg");
    startOp("divPosNeg", 4'd10, 32'd7, 32'hFFFF_FFFE, 32'd1, 32'hFFFF_FFFD, 1'b0);
    waitDone("divPosNeg", 0); sbCheck("divPosNeg");
    startOp("divZero", 4'd10, 32'd9, 32'd0, 32'd9, 32'hFFFF_FFFF, 1'b1);
    waitDone("divZero", 0); sbCheck("divZero");
    loadY(32'd8);
    loadMdr(32'd2);
    checkOutput("divZeroSticky", 64'(div_zero), 64'd1);
    startOp("divAfterZero", 4'd10, 32'd8, 32'd2, 32'd0, 32'd4, 1'b0);
    waitDone("divAfterZero", 0); sbCheck("divAfterZero");

    // Start accepted in the done cycle (Y=8, B=2 still selected)
    alu_op = 4'd9; alu_start = 1;
    sbQ.push_back('{32'd0, 32'd16, 1'b0});
    tick();
    alu_start = 0; alu_op = '0;
    checkOutput("b2b_busyRise", 64'(busy), 64'd1);
    checkOutput("b2b_doneLow", 64'(done), 64'd0);
    waitDone("b2b", 0); sbCheck("b2b");

    // Abort mid-operation
    startOp("abort", 4'd9, 32'd5, 32'd7, 32'd0, 32'd35, 1'b0);
    repeat (9) tick();
    clr = 1;
    #1;
    checkOutput("abortBusy", 64'(busy), 64'd0);
    checkOutput("abortDone", 64'(done), 64'd0);
    void'(sbQ.pop_front());
    tick();
    clr = 0;
    sawDone = 0;
    repeat (40) begin
      tick();
      if (done) sawDone = 1;
    end
    checkOutput("abortNoDone", 64'(sawDone), 64'd0);
    readBus(5'd19, v); checkOutput("abortZlo", 64'(v), 64'd0);
    readBus(5'd18, v); checkOutput("abortZhi", 64'(v), 64'd0);
    startOp("mulAfterAbort", 4'd9, 32'd3, 32'd4, 32'd0, 32'd12, 1'b0);
    waitDone("mulAfterAbort", 0); sbCheck("mulAfterAbort");

    checkOutput("sbDrained", 64'(sbQ.size()), 64'd0);
    $display("End of test - %0d assertions evaluated, %0d failures", assertCount, failCount);
    $finish;
  end

endmodule
